// File: rtl/c432_mon_pkg.sv
// Shared types and constants for the c432 response monitor: FSM states,
// response/signature widths, MISR seed and feedback taps.
package c432_mon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int RESP_W = 7;
   localparam int MISR_W = 16;
   localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;
   // x^16 + x^15 + x^13 + x^4 + 1 -> feedback from bits 15, 14, 12, 3
   localparam logic [MISR_W-1:0] MISR_TAPS = 16'hD008;

   function automatic logic [RESP_W-1:0] pack_resp(input logic       pa,
                                                   input logic       pb,
                                                   input logic       pc,
                                                   input logic [3:0] chan);
      return {pa, pb, pc, chan};
   endfunction

endpackage

// File: rtl/c432_misr.sv
// 16-bit multiple-input signature register folding one 7-bit c432 response
// per enabled cycle; seed load takes priority over compaction.
module c432_misr
   import c432_mon_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic              en,
   input  logic [RESP_W-1:0] data,
   output logic [MISR_W-1:0] sig
);

   logic fb;

   assign fb = ^(sig & MISR_TAPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= '0;
      end else if (seed_load) begin
         sig <= MISR_SEED;
      end else if (en) begin
         sig <= {sig[MISR_W-2:0], fb} ^ {{(MISR_W-RESP_W){1'b0}}, data};
      end
   end

endmodule

// File: rtl/c432_resp_monitor.sv
// Response monitor for the c432 interrupt controller: accepts one vector per
// handshake, waits a settle window, samples and compacts the response.
module c432_resp_monitor
   import c432_mon_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              vec_valid,
   output logic              vec_ready,
   input  logic              vec_last,
   input  logic              exp_valid,
   input  logic [RESP_W-1:0] exp_resp,
   input  logic              pa,
   input  logic              pb,
   input  logic              pc,
   input  logic [3:0]        chan,
   output logic [MISR_W-1:0] misr,
   output logic [CNT_W-1:0]  vec_count,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  first_err_idx,
   output logic [RESP_W-1:0] first_err_resp,
   output logic              err_seen,
   output logic              busy,
   output logic              done,
   output logic              pass
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t            state;
   logic [SW-1:0]     settle_cnt;
   logic [RESP_W-1:0] resp;
   logic [RESP_W-1:0] exp_resp_q;
   logic              exp_valid_q;
   logic              last_q;
   logic              accept;
   logic              mismatch;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign resp      = pack_resp(pa, pb, pc, chan);
   assign vec_ready = (state == ARMED);
   assign accept    = vec_ready && vec_valid && !start;
   assign mismatch  = exp_valid_q && (resp != exp_resp_q);
   assign busy      = (state != IDLE) && (state != DONE);
   assign done      = (state == DONE);
   assign pass      = done && (err_count == '0);

   c432_misr u_misr (
      .clk       (clk),
      .rst       (rst),
      .seed_load (start),
      .en        ((state == SAMPLE) && !start),
      .data      (resp),
      .sig       (misr)
   );

   // Per-vector expectation captured at the handshake; pure data, no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         exp_resp_q  <= exp_resp;
         exp_valid_q <= exp_valid;
         last_q      <= vec_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         vec_count      <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_resp <= '0;
         err_seen       <= 1'b0;
      end else if (start) begin
         state          <= ARMED;
         settle_cnt     <= '0;
         vec_count      <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_resp <= '0;
         err_seen       <= 1'b0;
      end else begin
         case (state)
            ARMED: begin
               if (vec_valid) begin
                  if (SETTLE_CYCLES > 0) begin
                     state      <= SETTLE;
                     settle_cnt <= SW'(SETTLE_CYCLES - 1);
                  end else begin
                     state <= SAMPLE;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            SAMPLE: begin
               vec_count <= sat_inc(vec_count);
               if (mismatch) begin
                  err_count <= sat_inc(err_count);
                  if (!err_seen) begin
                     first_err_idx  <= vec_count;
                     first_err_resp <= resp;
                     err_seen       <= 1'b1;
                  end
               end
               state <= last_q ? DONE : ARMED;
            end
            IDLE, DONE: state <= state;
            default:    state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/c432_resp_monitor.md
Name: c432_resp_monitor

Overview:
- Hardware response monitor that sits on the output side of the c432 27-channel interrupt controller.
- A vector driver handshakes each applied input vector to the monitor. The monitor waits a settle window, then samples the c432 response (PA, PB, PC, channel code).
- Each sample is compacted into a 16-bit MISR signature and compared against a supplied expected response. The block counts vectors and mismatches, and logs the first failure.
- It is the on-chip counterpart of the stimulus side and is used for lock/unlock functional checks of c432 instances.

Parameters:
- SETTLE_CYCLES, 2, cycles waited after vector acceptance before sampling (0 allowed).
- CNT_W, 16, width of the vector and error counters.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: clear statistics, seed the MISR, enter ARMED
- vec_valid  input  1  driver has applied a vector to the c432 inputs
- vec_ready  output  1  monitor accepts a vector (high only in ARMED)
- vec_last  input  1  qualifies vec_valid; marks the final vector of the session
- exp_valid  input  1  qualifies vec_valid; compare enabled for this vector
- exp_resp  input  7  expected {pa,pb,pc,chan[3:0]}
- pa, pb, pc  input  1 each  c432 out1..out3
- chan  input  4  c432 out4..out7 (out4 = MSB)
- misr  output  16  running signature
- vec_count  output  CNT_W  vectors sampled
- err_count  output  CNT_W  compare mismatches
- first_err_idx  output  CNT_W  vec_count value at the first mismatch
- first_err_resp  output  7  observed response at the first mismatch
- err_seen  output  1  at least one mismatch has occurred
- busy  output  1  state is not IDLE and not DONE
- done  output  1  level, held in DONE until start
- pass  output  1  done and err_count == 0

Behaviour:
- Response word: resp = {pa,pb,pc,chan[3]..chan[0]}, 7 bits, MSB = pa.
- Reset (async): state IDLE; every output is 0, including misr = 16'h0000.
- State IDLE: all outputs hold. On start, go to ARMED; vec_count, err_count, first_err_idx, first_err_resp and err_seen clear; misr loads 16'hFFFF.
- State ARMED: vec_ready = 1. When vec_valid and vec_ready are both high, latch exp_resp, exp_valid and vec_last.
  - If SETTLE_CYCLES > 0, go to SETTLE with the counter loaded to SETTLE_CYCLES-1.
  - Otherwise go to SAMPLE.
- State SETTLE: decrement each cycle; when the counter is 0, go to SAMPLE.
- State SAMPLE (one cycle): register resp; update the MISR; increment vec_count (saturating at all-ones).
  - If the latched exp_valid is set and resp != latched exp_resp: increment err_count (saturating).
  - On the first such mismatch, also capture first_err_idx (pre-increment vec_count) and first_err_resp, and set err_seen.
  - Next state: DONE if vec_last was latched, else ARMED.
- Latency: acceptance at edge T, sampling at edge T+1+SETTLE_CYCLES; vec_ready returns at T+2+SETTLE_CYCLES.
- The driver must hold the c432 inputs stable from acceptance until vec_ready returns.
- State DONE: done = 1 and all results hold. start restarts the session as from IDLE.
- MISR update:
  - fb = m[15]^m[14]^m[12]^m[3] (poly x^16+x^15+x^13+x^4+1).
  - m_next = {m[14:0], fb} ^ {9'b0, resp}.
- start in any non-IDLE state (including mid-SETTLE) aborts the session: the same clear and seed apply and the next state is ARMED. start has priority over a same-cycle handshake, so that vector is not accepted.
- vec_valid outside ARMED is ignored; the driver must keep it asserted until accepted.
- Counter saturation does not stop the MISR or sampling.

Decomposition:
- Package c432_mon_pkg:
  - state enum {IDLE, ARMED, SETTLE, SAMPLE, DONE}
  - RESP_W = 7
  - MISR_W = 16
  - MISR_SEED = 16'hFFFF
  - MISR tap constant
  - function pack_resp(pa,pb,pc,chan)
- One sub-module, c432_misr: 16-bit MISR with seed load, enable and a 7-bit data input; instantiated once.

Test Plan:
- Reset mid-SETTLE (SETTLE_CYCLES=2), then start -> all outputs 0 during rst; after start: misr=16'hFFFF, vec_ready=1, busy=1.
- Single vector, resp 7'h00, exp 7'h00, vec_last=1 -> sample 3 cycles after acceptance; misr=16'hFFFE, vec_count=1, err_count=0, done=1, pass=1.
- Single vector, pa=pb=pc=1, chan=4'hF, exp 7'h7F -> misr=16'hFF81, pass=1.
- Three vectors, expected 7'h10/7'h20/7'h30; the second observes 7'h21 -> err_count=1, first_err_idx=1, first_err_resp=7'h21, err_seen=1, pass=0, done after the third.
- vec_valid held high continuously with SETTLE_CYCLES=0 -> exactly one acceptance per 2 cycles; vec_ready low during SAMPLE.
- start pulsed in the same cycle as a handshake -> vector not accepted, statistics cleared, state ARMED; exp_valid=0 vectors never increment err_count.
